// File: rtl/pwm_divider_pkg.sv
// rtl/pwm_divider_pkg.sv - shared types and constants for the PWM divider
package pwm_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/pwm_divider_ch.sv
// rtl/pwm_divider_ch.sv - one PWM channel: shadow/active config, counter, FSM
module pwm_divider_ch
    import pwm_divider_pkg::*;
#(
    parameter int WIDTH       = 24,
    parameter int PERIOD_INIT = 10_000_000,
    parameter int DUTY_INIT   = 5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_period,
    input  logic [WIDTH-1:0] load_duty,
    input  logic             load_mode,
    output logic             clk_o,
    output logic             tick
);

    localparam logic [WIDTH-1:0] PERIOD_RST = WIDTH'(PERIOD_INIT);
    localparam logic [WIDTH-1:0] DUTY_RST   = WIDTH'(DUTY_INIT);
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

    ch_state_e        state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clk_o_q, clk_o_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] sh_period_q, sh_period_d;
    logic [WIDTH-1:0] sh_duty_q, sh_duty_d;
    logic             sh_mode_q, sh_mode_d;
    logic [WIDTH-1:0] act_period_q, act_period_d;
    logic [WIDTH-1:0] act_duty_q, act_duty_d;
    logic             act_mode_q, act_mode_d;
    logic             boundary;

    // Next-state logic: config shadowing, period counter, output compare and FSM
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clk_o_d      = 1'b0;
        tick_d       = 1'b0;
        sh_period_d  = sh_period_q;
        sh_duty_d    = sh_duty_q;
        sh_mode_d    = sh_mode_q;
        act_period_d = act_period_q;
        act_duty_d   = act_duty_q;
        act_mode_d   = act_mode_q;

        boundary = (state_q == ST_RUN) && (cnt_q == act_period_q);

        // A write always goes to the shadow; the active copy below reads the
        // old shadow, so a write on a boundary waits one more period.
        if (load) begin
            sh_period_d = load_period;
            sh_duty_d   = load_duty;
            sh_mode_d   = load_mode;
        end

        if (state_q == ST_IDLE || boundary) begin
            act_period_d = sh_period_q;
            act_duty_d   = sh_duty_q;
            act_mode_d   = sh_mode_q;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ONE;
                if (enable && act_period_q != '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // High for the last D cycles: cnt > P-D, evaluated as cnt+D > P
                // one bit wider so D >= P cannot wrap.
                clk_o_d = ({1'b0, cnt_q} + {1'b0, act_duty_q}) > {1'b0, act_period_q};
                tick_d  = boundary;
                cnt_d   = boundary ? CNT_ONE : cnt_q + CNT_ONE;
                if (boundary) begin
                    if (act_mode_q == MODE_ONESHOT) begin
                        state_d = ST_DONE;
                    end else if (sh_period_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                cnt_d = CNT_ONE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ONE;
            end
        endcase

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ONE;
            clk_o_d = 1'b0;
            tick_d  = 1'b0;
        end
    end

    // State register with synchronous reset to the initial configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ONE;
            clk_o_q      <= 1'b0;
            tick_q       <= 1'b0;
            sh_period_q  <= PERIOD_RST;
            sh_duty_q    <= DUTY_RST;
            sh_mode_q    <= MODE_CONT;
            act_period_q <= PERIOD_RST;
            act_duty_q   <= DUTY_RST;
            act_mode_q   <= MODE_CONT;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clk_o_q      <= clk_o_d;
            tick_q       <= tick_d;
            sh_period_q  <= sh_period_d;
            sh_duty_q    <= sh_duty_d;
            sh_mode_q    <= sh_mode_d;
            act_period_q <= act_period_d;
            act_duty_q   <= act_duty_d;
            act_mode_q   <= act_mode_d;
        end
    end

    assign clk_o = clk_o_q;
    assign tick  = tick_q;

endmodule

// File: rtl/pwm_divider.sv
// rtl/pwm_divider.sv - multi-channel PWM/clock divider top with load decode
module pwm_divider
    import pwm_divider_pkg::*;
#(
    parameter int CH          = 4,
    parameter int WIDTH       = 24,
    parameter int PERIOD_INIT = 10_000_000,
    parameter int DUTY_INIT   = 5_000_000
) (
    input  logic                                 clkI,
    input  logic                                 rst,
    input  logic [CH-1:0]                        enable,
    input  logic                                 load,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] load_ch,
    input  logic [WIDTH-1:0]                     load_period,
    input  logic [WIDTH-1:0]                     load_duty,
    input  logic                                 load_mode,
    output logic [CH-1:0]                        clkO,
    output logic [CH-1:0]                        tick
);

    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0] ch_load;

    // Route the write strobe to the addressed channel; indices >= CH match nothing
    always_comb begin
        ch_load = '0;
        for (int i = 0; i < CH; i++) begin
            ch_load[i] = load && (load_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        pwm_divider_ch #(
            .WIDTH      (WIDTH),
            .PERIOD_INIT(PERIOD_INIT),
            .DUTY_INIT  (DUTY_INIT)
        ) u_ch (
            .clk        (clkI),
            .rst        (rst),
            .enable     (enable[g]),
            .load       (ch_load[g]),
            .load_period(load_period),
            .load_duty  (load_duty),
            .load_mode  (load_mode),
            .clk_o      (clkO[g]),
            .tick       (tick[g])
        );
    end

endmodule
